qmem_bist_master: RTL and testbench
===================================

# qmem_bist_master

QMEM bus initiator that runs a four-pass memory self-test (write pattern, read/compare, write inverted pattern, read/compare) over a programmable window of 32-bit words. It drives the same QMEM slave port as the CPU, through the bus arbiter, to qualify the external SRAM path at boot or on demand. Results are reported as status registers for the control CPU.

## Interface
- AW, 32: QMEM address width (byte address).
- DW, 32: QMEM data width; only 32 supported.
- SW, DW/8: byte-select width.
- RD_DLY, 1: cycles after the ack-high cycle before dat_r is fully valid and sampled; range 0-3.
- TIMEOUT, 64: max cycles cs may stay high without ack before abort; range 2-65535.
- SEED, 32'hA5C3_0F96: pattern XOR constant.
- clk100  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle pulse; starts a test when not busy
- base  in  AW  window start byte address; bits [1:0] ignored (forced 0)
- count  in  16  number of 32-bit words; 0 = empty test
- adr  out  AW  QMEM address
- cs  out  1  QMEM chip select
- we  out  1  QMEM write enable
- sel  out  SW  byte selects; always 4'hF during a transfer
- dat_w  out  DW  write data
- dat_r  in  DW  read data
- ack  in  1  transfer acknowledge
- err  in  1  bus error; treated as a mismatch on that word
- busy  out  1  test in progress
- done  out  1  test finished; held until next start
- pass  out  1  valid with done: no mismatch, no timeout
- timeout  out  1  aborted on missing ack
- err_cnt  out  16  mismatch count, saturates at 16'hFFFF
- err_adr  out  AW  address of first mismatch
- err_dat  out  DW  read data of first mismatch

## Operation
- All outputs are registers; reset value 0 for every output.
- start is captured from IDLE or DONE: clears done/pass/timeout/err_cnt/err_adr/err_dat, latches base and count, sets busy. start while busy is ignored.
- count=0: IDLE -> DONE directly, one cycle later, pass=1.
- Pattern for byte address a: P(a) = a ^ SEED (a zero-extended to 32 bits). Phase 0 uses P(a), phase 1 uses ~P(a).
- States: IDLE, WR_REQ, WR_GAP, RD_REQ, RD_WAIT, CMP, DONE. Sequence: phase 0 writes, phase 0 reads, phase 1 writes, phase 1 reads, DONE.
- WR_REQ: cs=1, we=1, sel=4'hF, adr, dat_w held stable until ack sampled high; then cs<=0, enter WR_GAP (one cycle cs=0), advance address by 4; after last word reset address to base and go to RD_REQ.
- RD_REQ: cs=1, we=0, sel=4'hF; on ack sampled high cs<=0, enter RD_WAIT for RD_DLY cycles, then CMP.
- CMP (one cycle, cs=0): mismatch if dat_r != expected or err was high with ack. On mismatch: err_cnt increments (saturating); if first mismatch, capture err_adr/err_dat. Then next RD_REQ or next pass.
- Address wrap: base + 4*(count-1) wraps modulo 2^AW; no error.
- Timeout: cycle counter cleared when cs rises, counts while cs=1 and ack=0; on reaching TIMEOUT: cs<=0, timeout=1, pass=0, go DONE.
- DONE: busy=0, done=1, pass = (err_cnt==0) && !timeout.
- ack while cs=0 is ignored.

## Timing
- cs rises on the edge after start/gap; minimum one cs-low cycle between consecutive transfers.
- ack seen at edge n: cs low from n+1; read data sampled at edge n+RD_DLY+1... i.e. CMP occupies the cycle after RD_WAIT.
- Against a slave acking on the 2nd cs cycle with RD_DLY=1: write = 3 cycles/word, read = 4 cycles/word; total = 14*count + 1 cycles from start to done.
- Reset mid-test: cs, busy and all outputs drop asynchronously; no further transfer issued.

## Configuration
- QMEM_BIST_STOP_ON_ERR_EN defined: first mismatch ends the test immediately (CMP -> DONE), err_cnt=1, pass=0.
- Undefined: all four passes always complete; err_cnt counts every mismatching word.

## Test plan
- base=0x100, count=4, ideal SRAM slave -> 4 writes dat_w=0x100^SEED..0x10C^SEED, then inverted, done after 57 cycles, pass=1, err_cnt=0.
- Slave with data bit 5 stuck-at-0, count=8 -> pass=0, err_adr=first address whose pattern has bit5=1, err_cnt=number of such reads (without STOP_ON_ERR), err_cnt=1 with it.
- Slave never acks, TIMEOUT=64 -> cs high exactly 64 cycles, then cs=0, timeout=1, done=1, pass=0.
- count=0 -> no cs pulse, done=1 and pass=1 one cycle after start; start while busy -> ignored, counters unchanged.
- base=0xFFFF_FFF8, count=4 -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4; pass=1.
- rst asserted during RD_WAIT -> all outputs 0 same cycle; new start afterward runs a full clean test.

Source files
------------

// File: rtl/qmem_bist_master.sv
// rtl/qmem_bist_master.sv - QMEM four-pass memory self-test initiator (write P, read, write ~P, read).
// Optional QMEM_BIST_STOP_ON_ERR_EN: the first mismatch ends the test immediately.
module qmem_bist_master #(
    parameter int              AW      = 32,
    parameter int              DW      = 32,
    parameter int              SW      = DW/8,
    parameter int              RD_DLY  = 1,
    parameter int              TIMEOUT = 64,
    parameter logic [DW-1:0]   SEED    = 32'hA5C3_0F96
) (
    input  logic          clk100,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [15:0]   count,
    output logic [AW-1:0] adr,
    output logic          cs,
    output logic          we,
    output logic [SW-1:0] sel,
    output logic [DW-1:0] dat_w,
    input  logic [DW-1:0] dat_r,
    input  logic          ack,
    input  logic          err,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          timeout,
    output logic [15:0]   err_cnt,
    output logic [AW-1:0] err_adr,
    output logic [DW-1:0] err_dat
);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_GAP, RD_REQ, RD_WAIT, CMP, DONE} state_t;

    state_t        state, state_n;
    logic          phase, phase_n;
    logic [AW-1:0] base_q, base_n;
    logic [15:0]   cnt_q, cnt_n;
    logic [15:0]   wcnt, wcnt_n;
    logic [15:0]   to_cnt, to_cnt_n;
    logic [1:0]    dly_cnt, dly_n;
    logic          err_seen, err_seen_n;

    logic [AW-1:0] adr_n;
    logic          cs_n, we_n, busy_n, done_n, pass_n, timeout_n;
    logic [SW-1:0] sel_n;
    logic [DW-1:0] dat_w_n;
    logic [15:0]   err_cnt_n;
    logic [AW-1:0] err_adr_n;
    logic [DW-1:0] err_dat_n;

    logic          last_word, mismatch, stop;

    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a, input logic ph);
        logic [DW-1:0] p;
        p = DW'(a) ^ SEED;
        return ph ? ~p : p;
    endfunction

    always_comb begin
        state_n    = state;
        phase_n    = phase;
        base_n     = base_q;
        cnt_n      = cnt_q;
        wcnt_n     = wcnt;
        to_cnt_n   = '0;
        dly_n      = dly_cnt;
        err_seen_n = err_seen;
        adr_n      = adr;
        dat_w_n    = dat_w;
        timeout_n  = timeout;
        err_cnt_n  = err_cnt;
        err_adr_n  = err_adr;
        err_dat_n  = err_dat;
        mismatch   = 1'b0;
        stop       = 1'b0;
        last_word  = (wcnt == cnt_q - 16'd1);

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    timeout_n = 1'b0;
                    err_cnt_n = '0;
                    err_adr_n = '0;
                    err_dat_n = '0;
                    base_n    = base & ~AW'(3);
                    cnt_n     = count;
                    adr_n     = base & ~AW'(3);
                    phase_n   = 1'b0;
                    wcnt_n    = '0;
                    state_n   = (count == 16'd0) ? DONE : WR_REQ;
                end
            end
            WR_REQ: begin
                if (ack) begin
                    state_n = WR_GAP;
                end else if (to_cnt == 16'(TIMEOUT - 1)) begin
                    state_n   = DONE;
                    timeout_n = 1'b1;
                end else begin
                    to_cnt_n = to_cnt + 16'd1;
                end
            end
            WR_GAP: begin
                if (last_word) begin
                    wcnt_n  = '0;
                    adr_n   = base_q;
                    state_n = RD_REQ;
                end else begin
                    wcnt_n  = wcnt + 16'd1;
                    adr_n   = adr + AW'(4);
                    state_n = WR_REQ;
                end
            end
            RD_REQ: begin
                if (ack) begin
                    err_seen_n = err;
                    dly_n      = '0;
                    state_n    = (RD_DLY == 0) ? CMP : RD_WAIT;
                end else if (to_cnt == 16'(TIMEOUT - 1)) begin
                    state_n   = DONE;
                    timeout_n = 1'b1;
                end else begin
                    to_cnt_n = to_cnt + 16'd1;
                end
            end
            RD_WAIT: begin
                if (dly_cnt == 2'(RD_DLY - 1)) state_n = CMP;
                else                           dly_n   = dly_cnt + 2'd1;
            end
            CMP: begin
                mismatch = (dat_r != pattern(adr, phase)) || err_seen;
                if (mismatch) begin
                    if (err_cnt == 16'd0) begin
                        err_adr_n = adr;
                        err_dat_n = dat_r;
                    end
                    if (err_cnt != 16'hFFFF) err_cnt_n = err_cnt + 16'd1;
                end
`ifdef QMEM_BIST_STOP_ON_ERR_EN
                stop = mismatch;
`else
                stop = 1'b0;
`endif
                if (stop) begin
                    state_n = DONE;
                end else if (last_word) begin
                    if (phase) begin
                        state_n = DONE;
                    end else begin
                        phase_n = 1'b1;
                        wcnt_n  = '0;
                        adr_n   = base_q;
                        state_n = WR_REQ;
                    end
                end else begin
                    wcnt_n  = wcnt + 16'd1;
                    adr_n   = adr + AW'(4);
                    state_n = RD_REQ;
                end
            end
            default: state_n = IDLE;
        endcase

        // Bus outputs are registered: they follow the state being entered.
        cs_n   = (state_n == WR_REQ) || (state_n == RD_REQ);
        we_n   = (state_n == WR_REQ);
        sel_n  = cs_n ? '1 : '0;
        if (state_n == WR_REQ) dat_w_n = pattern(adr_n, phase_n);
        busy_n = !((state_n == IDLE) || (state_n == DONE));
        done_n = (state_n == DONE);
        pass_n = done_n && (err_cnt_n == 16'd0) && !timeout_n;
    end

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            phase    <= 1'b0;
            base_q   <= '0;
            cnt_q    <= '0;
            wcnt     <= '0;
            to_cnt   <= '0;
            dly_cnt  <= '0;
            err_seen <= 1'b0;
            adr      <= '0;
            cs       <= 1'b0;
            we       <= 1'b0;
            sel      <= '0;
            dat_w    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            timeout  <= 1'b0;
            err_cnt  <= '0;
            err_adr  <= '0;
            err_dat  <= '0;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            base_q   <= base_n;
            cnt_q    <= cnt_n;
            wcnt     <= wcnt_n;
            to_cnt   <= to_cnt_n;
            dly_cnt  <= dly_n;
            err_seen <= err_seen_n;
            adr      <= adr_n;
            cs       <= cs_n;
            we       <= we_n;
            sel      <= sel_n;
            dat_w    <= dat_w_n;
            busy     <= busy_n;
            done     <= done_n;
            pass     <= pass_n;
            timeout  <= timeout_n;
            err_cnt  <= err_cnt_n;
            err_adr  <= err_adr_n;
            err_dat  <= err_dat_n;
        end
    end

endmodule

// File: tb/tb_qmem_bist_master.sv
// tb/tb_qmem_bist_master.sv - directed bench for qmem_bist_master with a 2nd-cycle-ack SRAM slave.
module tb_qmem_bist_master;

    logic        clk100 = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base;
    logic [15:0] count;
    logic [31:0] adr;
    logic        cs, we;
    logic [3:0]  sel;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;
    logic        err;
    logic        busy, done, pass, timeout;
    logic [15:0] err_cnt;
    logic [31:0] err_adr, err_dat;

    qmem_bist_master dut (
        .clk100 (clk100),
        .rst    (rst),
        .start  (start),
        .base   (base),
        .count  (count),
        .adr    (adr),
        .cs     (cs),
        .we     (we),
        .sel    (sel),
        .dat_w  (dat_w),
        .dat_r  (dat_r),
        .ack    (ack),
        .err    (err),
        .busy   (busy),
        .done   (done),
        .pass   (pass),
        .timeout(timeout),
        .err_cnt(err_cnt),
        .err_adr(err_adr),
        .err_dat(err_dat)
    );

    always #5 clk100 = ~clk100;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Slave: 0 ideal SRAM, 1 read data bit 5 stuck at 0, 2 never acks.
    int          mode = 0;
    int          age  = 0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] wr_adr [64];
    logic [31:0] wr_dat [64];
    int          nwr = 0;

    always begin
        @(posedge clk100);
        #1;
        if (rst || !cs) begin
            ack = 1'b0;
            age = 0;
        end else if (ack) begin
            ack = 1'b0;
        end else begin
            age++;
            if (mode != 2 && age == 2) begin
                ack = 1'b1;
                if (we) begin
                    mem[adr] = dat_w;
                    if (nwr < 64) begin
                        wr_adr[nwr] = adr;
                        wr_dat[nwr] = dat_w;
                    end
                    nwr++;
                end else begin
                    dat_r = mem.exists(adr) ? mem[adr] : 32'h0;
                    if (mode == 1) dat_r = dat_r & ~32'h20;
                end
            end
        end
    end

    task automatic run_test(input logic [31:0] b, input logic [15:0] c, input int poke,
                            output int cyc, output int csh);
        nwr = 0;
        @(negedge clk100);
        base  = b;
        count = c;
        start = 1'b1;
        @(posedge clk100);
        #2;
        start = 1'b0;
        cyc   = 1;
        csh   = cs ? 1 : 0;
        while (!done && cyc < 3000) begin
            @(posedge clk100);
            #2;
            cyc++;
            if (cs) csh++;
            if (cyc == poke) begin
                base  = 32'h800;
                count = 16'd5;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    int cyc, csh, k;
    logic [15:0] exp_cnt;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        base  = '0;
        count = '0;
        ack   = 1'b0;
        err   = 1'b0;
        dat_r = '0;
        repeat (3) @(posedge clk100);
        #2;
        check_eq("rst_ctrl", {24'h0, cs, we, sel, busy, done}, 32'h0);
        check_eq("rst_stat", {15'h0, pass, timeout, err_cnt}, 32'h0);
        check_eq("rst_adr", adr | dat_w | err_adr | err_dat, 32'h0);
        @(negedge clk100);
        rst = 1'b0;

        // Ideal slave, base 0x100, four words.
        mode = 0;
        run_test(32'h100, 16'd4, 0, cyc, csh);
        check_eq("t1_cycles", cyc, 57);
        check_eq("t1_done_pass", {done, pass, busy, timeout}, 4'b1100);
        check_eq("t1_err_cnt", err_cnt, 0);
        check_eq("t1_nwr", nwr, 8);
        check_eq("t1_wd0", wr_dat[0], 32'hA5C30E96);
        check_eq("t1_wd1", wr_dat[1], 32'hA5C30E92);
        check_eq("t1_wd2", wr_dat[2], 32'hA5C30E9E);
        check_eq("t1_wd3", wr_dat[3], 32'hA5C30E9A);
        check_eq("t1_wa2", wr_adr[2], 32'h108);
        check_eq("t1_wd4_inv", wr_dat[4], 32'h5A3CF169);

        // Bit 5 stuck at 0: 0x20..0x2C fail in phase 0, 0x10..0x1C fail in phase 1.
        mode = 1;
        run_test(32'h10, 16'd8, 0, cyc, csh);
`ifdef QMEM_BIST_STOP_ON_ERR_EN
        exp_cnt = 16'd1;
`else
        exp_cnt = 16'd8;
        check_eq("t2_cycles", cyc, 113);
`endif
        check_eq("t2_pass", {done, pass}, 2'b10);
        check_eq("t2_err_cnt", err_cnt, exp_cnt);
        check_eq("t2_err_adr", err_adr, 32'h20);
        check_eq("t2_err_dat", err_dat, 32'hA5C30F96);

        // Slave never acks: abort after 64 cs-high cycles.
        mode = 2;
        run_test(32'h40, 16'd2, 0, cyc, csh);
        check_eq("t3_cs_high", csh, 64);
        check_eq("t3_cycles", cyc, 65);
        check_eq("t3_flags", {done, pass, timeout, cs, busy}, 5'b10100);

        // Empty test.
        mode = 0;
        run_test(32'h500, 16'd0, 0, cyc, csh);
        check_eq("t4_cycles", cyc, 1);
        check_eq("t4_cs_high", csh, 0);
        check_eq("t4_done_pass", {done, pass, timeout}, 3'b110);

        // Start pulse mid-test is ignored.
        run_test(32'h200, 16'd2, 10, cyc, csh);
        check_eq("t4b_cycles", cyc, 29);
        check_eq("t4b_nwr", nwr, 4);
        check_eq("t4b_wa3", wr_adr[3], 32'h204);
        check_eq("t4b_wd3", wr_dat[3], 32'h5A3CF26D);
        check_eq("t4b_pass", {done, pass, 16'(err_cnt)}, {2'b11, 16'h0});

        // Address wrap at top of space.
        run_test(32'hFFFF_FFF8, 16'd4, 0, cyc, csh);
        check_eq("t5_wa0", wr_adr[0], 32'hFFFF_FFF8);
        check_eq("t5_wa1", wr_adr[1], 32'hFFFF_FFFC);
        check_eq("t5_wa2", wr_adr[2], 32'h0);
        check_eq("t5_wa3", wr_adr[3], 32'h4);
        check_eq("t5_wd2", wr_dat[2], 32'hA5C30F96);
        check_eq("t5_pass", {done, pass, 16'(err_cnt)}, {2'b11, 16'h0});

        // Reset during RD_WAIT, then a clean rerun.
        @(negedge clk100);
        base  = 32'h300;
        count = 16'd2;
        start = 1'b1;
        @(posedge clk100);
        #2;
        start = 1'b0;
        k = 0;
        while (!(cs && !we && ack) && k < 200) begin
            @(posedge clk100);
            #2;
            k++;
        end
        check_eq("t6_rd_ack_seen", {31'h0, cs && !we && ack}, 32'h1);
        @(posedge clk100);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t6_rst_ctrl", {24'h0, cs, we, sel, busy, done}, 32'h0);
        check_eq("t6_rst_stat", {15'h0, pass, timeout, err_cnt}, 32'h0);
        check_eq("t6_rst_bus", adr | dat_w, 32'h0);
        csh = 0;
        repeat (4) begin
            @(posedge clk100);
            #2;
            if (cs) csh++;
        end
        check_eq("t6_no_cs_in_rst", csh, 0);
        @(negedge clk100);
        rst = 1'b0;
        run_test(32'h300, 16'd2, 0, cyc, csh);
        check_eq("t6_rerun_cycles", cyc, 29);
        check_eq("t6_rerun_pass", {done, pass, 16'(err_cnt)}, {2'b11, 16'h0});

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
